// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared defaults, duty-bus slicing helper and reset period constant
//            for the multi-channel PWM. Optional macro: PWM_CENTER_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int unsigned c_pwm_bits_def = 12;
  localparam int unsigned c_max_bits     = 32;
  localparam int unsigned c_max_ch       = 32;

  // Widest supported counter value; truncated to PWM_BITS it is all ones
  localparam logic [c_max_bits-1:0] c_period_rst = '1;

  typedef logic [c_max_bits*c_max_ch-1:0] duty_flat_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  function automatic logic [c_max_bits-1:0] duty_slice(
    input duty_flat_t  flat,
    input int unsigned ch,
    input int unsigned bits
  );
    duty_flat_t              shifted;
    logic [c_max_bits-1:0]   mask;
    shifted = flat >> (ch * bits);
    mask    = (bits >= c_max_bits) ? '1 : ((c_max_bits'(1) << bits) - c_max_bits'(1));
    return shifted[c_max_bits-1:0] & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_timebase.sv
// ============================================================================
// Module   : pwm_timebase
// Purpose  : Shared PWM counter, active period register, boundary and
//            period-done generation. PWM_CENTER_ALIGN_EN selects up/down count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = c_pwm_bits_def
) (
  input  logic                clk_pwm,
  input  logic                rst_in,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_period_sh,
  input  logic                i_pending,
  output logic [PWM_BITS-1:0] o_cnt,
  output logic                o_boundary,
  output logic                o_period_done
);

  localparam logic [PWM_BITS-1:0] c_one = PWM_BITS'(1);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_p_act;
  logic                r_done;
  logic                w_top;
  logic                w_boundary;

  assign w_top = (r_cnt == r_p_act);

`ifdef PWM_CENTER_ALIGN_EN
  pwm_dir_e r_dir;

  // With P_act==1 the top and the last down-count value coincide at cnt==1
  assign w_boundary = i_en && ((r_p_act == '0) ||
                      ((r_cnt == c_one) && ((r_dir == DIR_DOWN) || (r_p_act == c_one))));

  always_ff @(posedge clk_pwm) begin
    if (rst_in) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else if (!i_en || w_boundary) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else if (r_dir == DIR_DOWN) begin
      r_cnt <= r_cnt - c_one;
    end else if (w_top) begin
      r_cnt <= r_cnt - c_one;
      r_dir <= DIR_DOWN;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end
`else
  assign w_boundary = i_en && w_top;

  always_ff @(posedge clk_pwm) begin
    if (rst_in) begin
      r_cnt <= '0;
    end else if (!i_en || w_boundary) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end
`endif

  always_ff @(posedge clk_pwm) begin
    if (rst_in) begin
      r_p_act <= PWM_BITS'(c_period_rst);
      r_done  <= 1'b0;
    end else begin
      r_done <= w_boundary;
      if (w_boundary && i_pending) begin
        r_p_act <= i_period_sh;
      end
    end
  end

  assign o_cnt         = r_cnt;
  assign o_boundary    = w_boundary;
  assign o_period_done = r_done;

endmodule

`default_nettype wire

// File: rtl/pwm_multi.sv
// ============================================================================
// Module   : pwm_multi
// Purpose  : NUM_CH PWM channels on one programmable-period timebase with
//            shadowed, boundary-synchronous updates. Macro: PWM_CENTER_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = c_pwm_bits_def,
  parameter int unsigned NUM_CH   = 4
) (
  input  logic                       clk_pwm,
  input  logic                       rst_in,
  input  logic                       en_in,
  input  logic [PWM_BITS-1:0]        period_in,
  input  logic [NUM_CH*PWM_BITS-1:0] duty_in,
  input  logic                       load_in,
  output logic                       upd_pending_out,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic                       pwm_period_done
);

  logic [PWM_BITS-1:0] r_period_sh;
  logic                r_pending;
  logic [PWM_BITS-1:0] w_cnt;
  logic                w_boundary;
  logic                w_apply;
  logic                w_done;
  duty_flat_t          w_duty_flat;

  assign w_duty_flat = duty_flat_t'(duty_in);
  assign w_apply     = w_boundary && r_pending;

  pwm_timebase #(
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk_pwm       (clk_pwm),
    .rst_in        (rst_in),
    .i_en          (en_in),
    .i_period_sh   (r_period_sh),
    .i_pending     (r_pending),
    .o_cnt         (w_cnt),
    .o_boundary    (w_boundary),
    .o_period_done (w_done)
  );

  // A load on the boundary wins over the clear: the fresh values wait a period
  always_ff @(posedge clk_pwm) begin
    if (rst_in) begin
      r_period_sh <= PWM_BITS'(c_period_rst);
      r_pending   <= 1'b0;
    end else if (load_in) begin
      r_period_sh <= period_in;
      r_pending   <= 1'b1;
    end else if (w_boundary) begin
      r_pending   <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PWM_BITS-1:0] r_duty_sh;
      logic [PWM_BITS-1:0] r_duty_act;
      logic                r_out;

      always_ff @(posedge clk_pwm) begin
        if (rst_in) begin
          r_duty_sh  <= '0;
          r_duty_act <= '0;
          r_out      <= 1'b0;
        end else begin
          if (w_apply) begin
            r_duty_act <= r_duty_sh;
          end
          if (load_in) begin
            r_duty_sh <= PWM_BITS'(duty_slice(w_duty_flat, gi, PWM_BITS));
          end
          r_out <= en_in && (w_cnt < r_duty_act);
        end
      end

      assign pwm_out[gi] = r_out;
    end
  endgenerate

  assign upd_pending_out = r_pending;
  assign pwm_period_done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
// ============================================================================
// Module   : tb_pwm_multi
// Purpose  : Self-checking bench for pwm_multi (PWM_BITS=8, NUM_CH=4) against a
//            phase-based reference model. Honours PWM_CENTER_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_multi;

  localparam int unsigned PB = 8;
  localparam int unsigned NC = 4;
`ifdef PWM_CENTER_ALIGN_EN
  localparam bit c_center = 1'b1;
`else
  localparam bit c_center = 1'b0;
`endif

  logic            clk_pwm = 1'b0;
  logic            rst_in  = 1'b1;
  logic            en_in   = 1'b1;
  logic [PB-1:0]   period_in = '0;
  logic [NC*PB-1:0] duty_in  = '0;
  logic            load_in = 1'b0;
  logic            upd_pending_out;
  logic [NC-1:0]   pwm_out;
  logic            pwm_period_done;

  pwm_multi #(.PWM_BITS(PB), .NUM_CH(NC)) dut (
    .clk_pwm         (clk_pwm),
    .rst_in          (rst_in),
    .en_in           (en_in),
    .period_in       (period_in),
    .duty_in         (duty_in),
    .load_in         (load_in),
    .upd_pending_out (upd_pending_out),
    .pwm_out         (pwm_out),
    .pwm_period_done (pwm_period_done)
  );

  always #5 clk_pwm = ~clk_pwm;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: active/shadow settings plus phase index within the period
  int m_p, s_p, m_k;
  int m_d [NC];
  int s_d [NC];
  bit m_pend;
  logic [NC-1:0] e_out;
  logic          e_done, e_pend;
  int hi [NC];
  int n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int plen(input int p);
    if (c_center) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  function automatic int cnt_at(input int p, input int k);
    if (c_center && k > p) return 2 * p - k;
    return k;
  endfunction

  // Cycles high per period for a given duty, from the counting pattern
  function automatic int exp_highs(input int p, input int d);
    if (!c_center) return (d > p) ? p + 1 : d;
    if (p == 0) return (d != 0) ? 1 : 0;
    if (d == 0) return 0;
    if (d > p) return 2 * p;
    return 2 * d - 1;
  endfunction

  task automatic model_step();
    int  len, cnt;
    bit  bnd;
    if (rst_in) begin
      m_p = 255; s_p = 255; m_k = 0; m_pend = 0;
      for (int i = 0; i < NC; i++) begin m_d[i] = 0; s_d[i] = 0; end
      e_out = '0; e_done = 1'b0; e_pend = 1'b0;
      return;
    end
    len = plen(m_p);
    cnt = cnt_at(m_p, m_k);
    bnd = en_in && (m_k == len - 1);
    e_done = bnd;
    for (int i = 0; i < NC; i++) e_out[i] = en_in && (cnt < m_d[i]);
    if (!en_in || bnd) m_k = 0; else m_k++;
    if (bnd && m_pend) begin
      m_p = s_p;
      for (int i = 0; i < NC; i++) m_d[i] = s_d[i];
    end
    if (load_in) begin
      s_p = int'(period_in);
      for (int i = 0; i < NC; i++) s_d[i] = int'(duty_in[i*PB +: PB]);
      m_pend = 1'b1;
    end else if (bnd) begin
      m_pend = 1'b0;
    end
    e_pend = m_pend;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_pwm);
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(e_out));
    chk("period_done", 32'(pwm_period_done), 32'(e_done));
    chk("upd_pending", 32'(upd_pending_out), 32'(e_pend));
    for (int i = 0; i < NC; i++) hi[i] += int'(pwm_out[i]);
    n_done += int'(pwm_period_done);
    load_in = 1'b0;
  endtask

  task automatic clr_win();
    for (int i = 0; i < NC; i++) hi[i] = 0;
    n_done = 0;
  endtask

  task automatic do_load(input logic [PB-1:0] p, input logic [NC*PB-1:0] d);
    period_in = p;
    duty_in   = d;
    load_in   = 1'b1;
    tick();
  endtask

  task automatic wait_applied(input string tag);
    for (int n = 0; n < 600 && upd_pending_out; n++) tick();
    chk(tag, 32'(upd_pending_out), 32'd0);
  endtask

  initial begin
    bit [7:0] pat;
    int       p, len;
    logic [NC*PB-1:0] d;

    // Reset and defaults: outputs low, done once per 256-cycle default period
    rst_in = 1'b1; en_in = 1'b1;
    tick(); tick();
    chk("rst_out", 32'(pwm_out), 32'd0);
    rst_in = 1'b0;
    clr_win();
    repeat (512) tick();
    chk("dflt_done_cnt", 32'(n_done), 32'(512 / plen(255)));
    chk("dflt_highs", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);

    // Basic duty
    do_load(8'd9, {8'd10, 8'd9, 8'd3, 8'd0});
    wait_applied("basic_apply");
    clr_win();
    len = plen(9);
    repeat (len) tick();
    chk("basic_ch0", 32'(hi[0]), 32'(exp_highs(9, 0)));
    chk("basic_ch1", 32'(hi[1]), 32'(exp_highs(9, 3)));
    chk("basic_ch2", 32'(hi[2]), 32'(exp_highs(9, 9)));
    chk("basic_ch3", 32'(hi[3]), 32'(exp_highs(9, 10)));
    chk("basic_done", 32'(n_done), 32'd1);

    // Glitch-free mid-period update of ch1
    for (int n = 0; n < 40 && m_k != 4; n++) tick();
    do_load(8'd9, {8'd10, 8'd9, 8'd7, 8'd0});
    chk("mid_pending", 32'(upd_pending_out), 32'd1);
    wait_applied("mid_apply");
    clr_win();
    repeat (len) tick();
    chk("mid_ch1", 32'(hi[1]), 32'(exp_highs(9, 7)));

    // Load exactly on the boundary while another update is pending
    do_load(8'd6, {8'd2, 8'd7, 8'd1, 8'd4});
    for (int n = 0; n < 40 && m_k != plen(m_p) - 1; n++) tick();
    do_load(8'd4, {8'd5, 8'd0, 8'd2, 8'd3});
    chk("bnd_pending", 32'(upd_pending_out), 32'd1);
    chk("bnd_done", 32'(pwm_period_done), 32'd1);
    repeat (30) tick();

    // Enable drop at cnt==5, then restart
    do_load(8'd9, {8'd8, 8'd6, 8'd4, 8'd2});
    wait_applied("en_apply");
    for (int n = 0; n < 40 && cnt_at(m_p, m_k) != 5; n++) tick();
    en_in = 1'b0;
    tick();
    chk("en_low_out", 32'(pwm_out), 32'd0);
    do_load(8'd3, {8'd1, 8'd2, 8'd3, 8'd4});
    repeat (4) tick();
    en_in = 1'b1;
    repeat (20) tick();

    // Reset in mid-period
    for (int n = 0; n < 40 && m_k != 2; n++) tick();
    rst_in = 1'b1;
    tick();
    chk("midrst_done", 32'(pwm_period_done), 32'd0);
    rst_in = 1'b0;
    repeat (5) tick();

`ifdef PWM_CENTER_ALIGN_EN
    // Centre-aligned P=4, duty 2: pattern over cnt 0,1,2,3,4,3,2,1
    do_load(8'd4, {8'd0, 8'd0, 8'd0, 8'd2});
    wait_applied("ctr_apply");
    pat = 8'b1000_0011;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("ctr_pat", 32'(pwm_out[0]), 32'(pat[j]));
      chk("ctr_done", 32'(pwm_period_done), 32'(j == 7));
    end
`endif

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) rst_in = 1'b1;
      if ($urandom_range(0, 49) == 0) en_in = ~en_in;
      if ($urandom_range(0, 11) == 0) begin
        p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 24));
        for (int i = 0; i < NC; i++) begin
          case ($urandom_range(0, 9))
            0:       d[i*PB +: PB] = 8'd0;
            1:       d[i*PB +: PB] = 8'hff;
            default: d[i*PB +: PB] = 8'($urandom_range(0, p + 2));
          endcase
        end
        period_in = 8'(p);
        duty_in   = d;
        load_in   = 1'b1;
      end
      tick();
      rst_in = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
